// File: rtl/usb_fs_phy_tx_if.sv
// usb_fs_phy_tx_if: UTMI transmit handshake and USB pin bundle
interface usb_fs_phy_tx_if;
  logic [7:0] utmi_data_i;
  logic utmi_txvalid_i;
  logic utmi_txready_o;
  logic usb_dp_o;
  logic usb_dn_o;
  logic usb_oe_o;
  modport master(output utmi_data_i, utmi_txvalid_i, input utmi_txready_o, usb_dp_o, usb_dn_o, usb_oe_o);
  modport slave(input utmi_data_i, utmi_txvalid_i, output utmi_txready_o, usb_dp_o, usb_dn_o, usb_oe_o);
endinterface

// File: rtl/usb_fs_phy_tx.sv
// usb_fs_phy_tx: full-speed USB transmit PHY (SYNC, NRZI with bit stuffing, EOP)
module usb_fs_phy_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input logic clk_i,
  input logic rst_i,
  usb_fs_phy_tx_if.slave bus
);
  localparam int PW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;
  state_t state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic [2:0] bit_idx, bit_n, ones, ones_n;
  logic [7:0] shift, shift_n;
  logic line, line_n, stuff, stuff_n, bflag, bflag_n;
  logic dp, dp_n, dn, dn_n, oe, oe_n;
  logic slot_end, last_slot, nb;
  assign slot_end = phase == PW'(CLKS_PER_BIT - 1);
  assign last_slot = bit_idx == 3'd7 && (stuff || ones != 3'd6);
  assign nb = bit_idx == 3'd7 ? bus.utmi_data_i[0] : shift[1];
  assign bus.utmi_txready_o = bflag & bus.utmi_txvalid_i;
  assign bus.usb_dp_o = dp;
  assign bus.usb_dn_o = dn;
  assign bus.usb_oe_o = oe;
  // State and line registers; reset parks the bus released at J
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      phase <= '0;
      bit_idx <= '0;
      ones <= '0;
      shift <= '0;
      line <= 1'b1;
      stuff <= 1'b0;
      bflag <= 1'b0;
      dp <= 1'b1;
      dn <= 1'b0;
      oe <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      bit_idx <= bit_n;
      ones <= ones_n;
      shift <= shift_n;
      line <= line_n;
      stuff <= stuff_n;
      bflag <= bflag_n;
      dp <= dp_n;
      dn <= dn_n;
      oe <= oe_n;
    end
  // Next bit slot: stuff owed, next data bit, byte boundary or EOP sequencing
  always_comb begin
    state_n = state;
    phase_n = state == IDLE || slot_end ? '0 : phase + 1'b1;
    bit_n = bit_idx;
    ones_n = ones;
    shift_n = shift;
    line_n = line;
    stuff_n = stuff;
    bflag_n = 1'b0;
    dp_n = dp;
    dn_n = dn;
    oe_n = oe;
    case (state)
      IDLE:
        if (bus.utmi_txvalid_i) begin
          state_n = SYNC;
          bit_n = '0;
          ones_n = '0;
          stuff_n = 1'b0;
          shift_n = 8'h80;
          line_n = 1'b0;
          oe_n = 1'b1;
          dp_n = 1'b0;
          dn_n = 1'b1;
        end
      SYNC, DATA: begin
        bflag_n = phase == PW'(CLKS_PER_BIT - 2) && last_slot;
        if (slot_end) begin
          if (!stuff && ones == 3'd6) begin
            stuff_n = 1'b1;
            ones_n = '0;
            line_n = ~line;
          end else if (bit_idx == 3'd7 && !bus.utmi_txvalid_i) begin
            state_n = EOP_SE0;
            bit_n = '0;
            stuff_n = 1'b0;
          end else begin
            state_n = bit_idx == 3'd7 ? DATA : state;
            shift_n = bit_idx == 3'd7 ? bus.utmi_data_i : shift >> 1;
            bit_n = bit_idx + 3'd1;
            stuff_n = 1'b0;
            ones_n = nb ? (ones == 3'd6 ? ones : ones + 3'd1) : '0;
            line_n = nb ? line : ~line;
          end
          dp_n = state_n == EOP_SE0 ? 1'b0 : line_n;
          dn_n = state_n == EOP_SE0 ? 1'b0 : ~line_n;
        end
      end
      EOP_SE0:
        if (slot_end) begin
          bit_n = bit_idx + 3'd1;
          state_n = bit_idx[0] ? EOP_J : EOP_SE0;
          dp_n = bit_idx[0];
        end
      EOP_J:
        if (slot_end) begin
          state_n = IDLE;
          oe_n = 1'b0;
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/usb_fs_phy_tx.md
# usb_fs_phy_tx

Full-speed (12 Mb/s) USB transmit PHY for the host side of the UTMI link. It sits between the host controller's UTMI transmit outputs and the FPGA USB D+/D- pins. It accepts bytes over the UTMI txvalid/txready handshake and drives them onto the wire. On the wire it generates SYNC, LSB-first NRZI data with bit stuffing, and EOP, then releases the bus.

## Interface
Parameters:
- CLKS_PER_BIT, default 4: clk_i cycles per USB bit time (48 MHz / 12 Mb/s). Legal values are 2 or more.

Ports:
- clk_i  in  1  system clock (48 MHz); one clock, all logic on its rising edge
- rst_i  in  1  synchronous, active-high reset
- utmi_data_i  in  8  byte to send (host utmi_data_out_o); must be stable while utmi_txvalid_i=1 until accepted
- utmi_txvalid_i  in  1  host has a byte / packet in progress
- utmi_txready_o  out  1  byte on utmi_data_i accepted this cycle
- usb_dp_o  out  1  D+ level
- usb_dn_o  out  1  D- level
- usb_oe_o  out  1  pin output enable (1 = PHY drives bus)

## Operation
- Line states: J = (dp=1, dn=0), K = (dp=0, dn=1), SE0 = (0, 0).
- States:
  - IDLE: oe=0, dp/dn=J. Samples utmi_txvalid_i every cycle; if it is 1, go to SYNC.
  - SYNC: sends 8'h80 LSB-first (KJKJKJKK).
  - DATA: shifts out the held byte LSB-first.
  - EOP_SE0: 2 bit times of SE0.
  - EOP_J: 1 bit time of J, then IDLE.
- NRZI: a 0 bit toggles the line (J↔K); a 1 bit holds it. The line level before SYNC is J.
- Bit stuffing:
  - A 3-bit ones counter counts consecutive 1s, starting from the first SYNC bit. The trailing SYNC 1 counts, so the counter is 1 after SYNC.
  - After the 6th consecutive 1, the next bit slot carries a stuffed 0 (a toggle) and the counter clears. Any 0 bit also clears the counter.
  - The stuffed bit is not a data bit. It delays the byte boundary by one bit time.
  - A stuff bit owed after the last data bit is sent before EOP.
- Byte boundary: the final clock of the last bit slot of SYNC or of a data byte, including any stuff bit that follows bit 7.
  - utmi_txready_o = boundary_flag AND utmi_txvalid_i. boundary_flag is registered; the path from utmi_txvalid_i to utmi_txready_o is combinational.
  - If utmi_txready_o=1, utmi_data_i loads into the shift register and DATA continues.
  - If utmi_txvalid_i=0 at the boundary, go to EOP_SE0.
- utmi_txvalid_i is ignored everywhere except in IDLE and at byte boundaries. Deassertion mid-byte has no effect. Assertion during EOP does not start a packet until IDLE is reached.
- Counters:
  - Phase counter: $clog2(CLKS_PER_BIT) bits, wraps at CLKS_PER_BIT-1.
  - Bit index: 3 bits, wraps 7→0.
  - Ones counter: saturates logic at 6.
- Reset: any cycle, including mid-packet, returns to IDLE on the next edge.

## Timing
- Reset values: usb_oe_o=0, usb_dp_o=1, usb_dn_o=0, utmi_txready_o=0.
- usb_dp_o, usb_dn_o and usb_oe_o are registered.
- Packet start:
  - utmi_txvalid_i=1 sampled in IDLE at cycle 0 → oe=1 and first SYNC K at cycle 1.
  - Bit slot n (counting stuff slots) occupies cycles 1+n·CLKS_PER_BIT through (n+1)·CLKS_PER_BIT.
- First utmi_txready_o, CLKS_PER_BIT=4: cycle 32. First data bit on the line at cycle 33.
- Without stuffing, each following boundary comes exactly 8·CLKS_PER_BIT cycles later.
- EOP: SE0 for 2·CLKS_PER_BIT cycles, then J for CLKS_PER_BIT cycles. oe=0 on the following cycle (IDLE, J).
- A new packet can start on the first IDLE cycle.

## Test plan
- Reset: hold rst_i 3 cycles with txvalid=1 → dp=1, dn=0, oe=0, txready=0 throughout reset.
- Single byte 0xA5, txvalid dropped after accept (CLKS_PER_BIT=4):
  - SYNC KJKJKJKK on cycles 1–32; txready=1 at cycle 32 only.
  - Data K,J,J,K,J,J,K,K on cycles 33–64; txready=0 at cycle 64.
  - SE0 cycles 65–72, J 73–76, oe=0 from cycle 77.
- Two bytes 0xC3, 0x00:
  - txready at cycles 32 and 64; no stuffing.
  - SE0 97–104, J 105–108, oe=0 at 109.
  - txvalid toggled low for one cycle at cycle 80 → no effect.
- Stuffing mid-byte, 0xFF:
  - Stuffed toggle in slot 13 (cycles 53–56) after data bit 4.
  - Byte spans 9 slots; boundary at cycle 68, SE0 starts cycle 69.
- Stuffing at end, 0xFC: six 1s in bits 2–7 → stuff slot cycles 65–68, then SE0 from cycle 69 (no EOP before the stuff bit).
- Reset mid-packet at cycle 40 with txvalid held 1 → cycle 41 idle (oe=0, J); new SYNC K starts one cycle after the first IDLE sample of txvalid.
